// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - word-indexed instruction memory with boot image, combinational read, synchronous write
// Optional IMEM_FAULT_EN: adds fault output and returns NOP for out-of-range reads.
module instruction_memory #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
`ifdef IMEM_FAULT_EN
  ,
  output logic              fault
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_wr_idx;

  function automatic logic [DATA_W-1:0] boot_word(input int idx);
    case (idx)
      0:       return DATA_W'(32'h0050_0093);
      1:       return DATA_W'(32'h0030_0113);
      2:       return DATA_W'(32'h0020_81B3);
      3:       return DATA_W'(32'h4020_8233);
      4:       return DATA_W'(32'h0020_F2B3);
      5:       return DATA_W'(32'h0020_E333);
      6:       return DATA_W'(32'h0030_2023);
      7:       return DATA_W'(32'h0000_2383);
      8:       return DATA_W'(32'h0000_006F);
      default: return '0;
    endcase
  endfunction

  // Compare one bit wider so DEPTH == 2^ADDR_W does not wrap to zero.
  assign w_rd_ok  = ({1'b0, A}  < DEPTH_EXT);
  assign w_wr_ok  = ({1'b0, wa} < DEPTH_EXT);
  assign w_rd_idx = A[IDX_W-1:0];
  assign w_wr_idx = wa[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= boot_word(i);
      end
    end else if (we && w_wr_ok) begin
      r_mem[w_wr_idx] <= wd;
    end
  end

`ifdef IMEM_FAULT_EN
  always_comb begin
    fault = 1'b0;
    D     = r_mem[w_rd_idx];
    if (!w_rd_ok) begin
      fault = 1'b1;
      D     = DATA_W'(32'h0000_0013);
    end
  end
`else
  always_comb begin
    D = r_mem[w_rd_idx];
    if (!w_rd_ok) begin
      D = '0;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - self-checking bench for instruction_memory
// Build with or without IMEM_FAULT_EN; expectations follow the macro.
module tb_instruction_memory;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] D;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        fault;

  int n_tests;
  int n_fail;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic        f;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        f;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  instruction_memory #(.DEPTH(256), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .A(A),
    .D(D),
    .we(we),
    .wa(wa),
    .wd(wd)
`ifdef IMEM_FAULT_EN
    ,
    .fault(fault)
`endif
  );

`ifndef IMEM_FAULT_EN
  assign fault = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] boot_ref(input int idx);
    logic [31:0] img [9];
    img = '{32'h00500093, 32'h00300113, 32'h002081B3, 32'h40208233,
            32'h0020F2B3, 32'h0020E333, 32'h00302023, 32'h00002383,
            32'h0000006F};
    if (idx >= 0 && idx < 9) return img[idx];
    return 32'h0;
  endfunction

  function automatic logic [31:0] oor_data();
`ifdef IMEM_FAULT_EN
    return 32'h00000013;
`else
    return 32'h00000000;
`endif
  endfunction

  function automatic logic oor_fault();
`ifdef IMEM_FAULT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic expect_d(input string name, input logic [31:0] d, input logic f);
    exp_t e;
    e.name = name;
    e.d    = d;
    e.f    = f;
    sb_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got D=%08h with no expected entry", D);
      return;
    end
    e = sb_q.pop_front();
    n_tests++;
    if (D !== e.d || fault !== e.f) begin
      n_fail++;
      $display("FAIL %s: A=%0d got D=%08h fault=%b, want D=%08h fault=%b",
               e.name, A, D, fault, e.d, e.f);
    end
  endtask

  task automatic read_check(input string name, input logic [31:0] addr,
                            input logic [31:0] d, input logic f);
    A = addr;
    expect_d(name, d, f);
    #1;
    sample();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    we  = 1'b0;
    wa  = '0;
    wd  = '0;
    A   = '0;

    for (int i = 0; i < 256; i++) vecs.push_back('{a: i, d: boot_ref(i), f: 1'b0});
    vecs.push_back('{a: 32'd256,        d: oor_data(), f: oor_fault()});
    vecs.push_back('{a: 32'hFFFF_FFFF,  d: oor_data(), f: oor_fault()});

    #1;
    expect_d("reset_a0", 32'h00500093, 1'b0);
    sample();
    A = 32'd8;
    #1;
    expect_d("reset_a8", 32'h0000006F, 1'b0);
    sample();

    #8 rst = 1'b0;

    // Sweep: changes land just after each negedge, samples 1 ns later.
    foreach (vecs[k]) begin
      A = vecs[k].a;
      expect_d($sformatf("sweep_%0d", k), vecs[k].d, vecs[k].f);
      #1;
      sample();
      #9;
    end

    read_check("comb_a2", 32'd2, 32'h002081B3, 1'b0);

    @(negedge clk);
    we = 1'b1; wa = 32'd20; wd = 32'hDEADBEEF;
    read_check("pre_edge_a20", 32'd20, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    we = 1'b0;
    read_check("post_edge_a20", 32'd20, 32'hDEADBEEF, 1'b0);

    @(negedge clk);
    we = 1'b1; wa = 32'd3; wd = 32'h12345678;
    @(posedge clk);
    #1;
    we = 1'b0;
    read_check("patched_a3", 32'd3, 32'h12345678, 1'b0);
    #2 rst = 1'b1;
    read_check("rst_restore_a3", 32'd3, 32'h40208233, 1'b0);
    read_check("rst_clear_a20", 32'd20, 32'h0, 1'b0);
    #1 rst = 1'b0;

    @(negedge clk);
    we = 1'b1; wa = 32'd300; wd = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    we = 1'b0;
    read_check("oor_write_alias44", 32'd44, 32'h0, 1'b0);
    read_check("oor_write_a0", 32'd0, 32'h00500093, 1'b0);
    read_check("oor_read_a300", 32'd300, oor_data(), oor_fault());

    @(negedge clk);
    rst = 1'b1;
    we = 1'b1; wa = 32'd10; wd = 32'h55AA55AA;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    we  = 1'b0;
    read_check("rst_blocks_write_a10", 32'd10, 32'h0, 1'b0);
    read_check("after_rst_a7", 32'd7, 32'h00002383, 1'b0);

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
